// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared command, key-code and FSM state definitions for the keypad command path
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LEFT,
        CMD_RIGHT,
        CMD_ROTATE,
        CMD_SOFT,
        CMD_HARD
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HOLD_DAS,
        ST_HOLD_ARR,
        ST_RELEASE
    } state_e;

    localparam logic [3:0] KEY_LEFT  = 4'd7;
    localparam logic [3:0] KEY_RIGHT = 4'd9;
    localparam logic [3:0] KEY_ROT   = 4'd5;
    localparam logic [3:0] KEY_SOFT  = 4'd8;
    localparam logic [3:0] KEY_HARD  = 4'd0;

    function automatic logic is_repeat(cmd_e c);
        return (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_SOFT);
    endfunction

endpackage

// File: rtl/cmd_fifo2.sv
// rtl/cmd_fifo2.sv - two-entry in-order valid/ready queue of game commands
module cmd_fifo2
    import tetris_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_e push_cmd,
    input  logic cmd_ready,
    output logic cmd_valid,
    output cmd_e cmd,
    output logic full,
    output logic drop
);

    cmd_e       mem0;
    cmd_e       mem1;
    logic [1:0] count;
    logic       pop;
    logic       accept;

    // mem0 is the head; unused slots are kept at CMD_NONE so cmd reads NONE when empty
    assign cmd_valid = (count != 2'd0);
    assign cmd       = mem0;
    assign full      = (count == 2'd2);
    assign pop       = cmd_valid & cmd_ready;
    assign accept    = push & (~full | pop);
    assign drop      = push & full & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem0  <= CMD_NONE;
            mem1  <= CMD_NONE;
            count <= 2'd0;
        end else begin
            case ({pop, accept})
                2'b10: begin
                    mem0  <= mem1;
                    mem1  <= CMD_NONE;
                    count <= count - 2'd1;
                end
                2'b01: begin
                    if (count == 2'd0) mem0 <= push_cmd;
                    else               mem1 <= push_cmd;
                    count <= count + 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        mem0 <= push_cmd;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= push_cmd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/key_cmd_repeater.sv
// rtl/key_cmd_repeater.sv - debounces scanned keys and emits auto-repeating game commands into a queue
module key_cmd_repeater
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 3,
    parameter int DAS_TICKS      = 16,
    parameter int ARR_TICKS      = 4,
    parameter int CW             = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       cmd_valid,
    output cmd_e       cmd,
    input  logic       cmd_ready,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [CW-1:0] DAS_LAST = CW'(DAS_TICKS - 1);
    localparam logic [CW-1:0] ARR_LAST = CW'(ARR_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit            DEB_ONE  = (DEBOUNCE_TICKS == 1);

    function automatic cmd_e map_key(logic [3:0] code);
        case (code)
            KEY_LEFT:  return CMD_LEFT;
            KEY_RIGHT: return CMD_RIGHT;
            KEY_ROT:   return CMD_ROTATE;
            KEY_SOFT:  return CMD_SOFT;
            KEY_HARD:  return CMD_HARD;
            default:   return CMD_NONE;
        endcase
    endfunction

    state_e        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [4:0]    cur_smp, cur_nxt;
    logic [4:0]    sample;
    logic          stable;
    logic          rep;
    logic          push;
    cmd_e          push_cmd;
    logic          fifo_full;
    logic          fifo_drop;

    // the code is meaningless while no key is down, so released samples collapse to one value
    assign sample = key_valid ? {1'b1, key_code} : 5'd0;
    assign stable = (sample == cur_smp);
    assign rep    = is_repeat(map_key(cur_smp[3:0]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cur_smp <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cur_smp <= cur_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cur_nxt   = cur_smp;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        cur_nxt = sample;
                        if (DEB_ONE) begin
                            state_nxt = ST_HOLD_DAS;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = ST_DEBOUNCE;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!stable) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_nxt = ST_HOLD_DAS;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_HOLD_DAS, ST_HOLD_ARR: begin
                    if (!stable) begin
                        state_nxt = ST_RELEASE;
                        cnt_nxt   = CNT_ONE;
                        cur_nxt   = sample;
                    end else if (state == ST_HOLD_DAS) begin
                        if (rep && cnt == DAS_LAST) begin
                            state_nxt = ST_HOLD_ARR;
                            cnt_nxt   = '0;
                        end else if (cnt != '1) begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end else if (cnt == ARR_LAST) begin
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (!stable) begin
                        cnt_nxt = CNT_ONE;
                        cur_nxt = sample;
                    end else if (cnt >= DEB_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = cur_smp[4] ? ST_HOLD_DAS : ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        push     = 1'b0;
        push_cmd = map_key((state == ST_IDLE) ? key_code : cur_smp[3:0]);
        if (tick) begin
            case (state)
                ST_IDLE:     push = key_valid && DEB_ONE;
                ST_DEBOUNCE: push = stable && (cnt == DEB_LAST);
                ST_HOLD_DAS: push = stable && rep && (cnt == DAS_LAST);
                ST_HOLD_ARR: push = stable && (cnt == ARR_LAST);
                ST_RELEASE:  push = stable && (cnt >= DEB_LAST) && cur_smp[4];
                default:     push = 1'b0;
            endcase
        end
        push = push && (push_cmd != CMD_NONE);
    end

    cmd_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_cmd  (push_cmd),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      ovf <= 1'b0;
        else if (fifo_drop && fifo_full) ovf <= 1'b1;
        else if (ovf_clr)                ovf <= 1'b0;
    end

endmodule

// File: tb/tb_key_cmd_repeater.sv
// tb/tb_key_cmd_repeater.sv - scoreboard bench for key_cmd_repeater with a tick every 4 clks
module tb_key_cmd_repeater;
    import tetris_pkg::*;

    localparam int DAS = 16;
    localparam int ARR = 4;
    localparam int NV  = 19;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       cmd_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       cmd_valid;
    logic       ovf;
    cmd_e       cmd;

    int   total = 0;
    int   bad = 0;
    int   tick_num = 0;
    int   last_tick = 0;
    int   ph = 0;
    int   base = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        cmd_e c;
        int   at;
    } exp_t;

    typedef struct {
        logic       kv;
        logic [3:0] code;
        int         nticks;
        cmd_e       ecmd;
        int         first;
        int         n;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    key_cmd_repeater dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .key_valid (key_valid),
        .key_code  (key_code),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #2;
    endtask

    // monitor and tick generator share the falling edge; checks run before the next tick is driven
    always @(negedge clk) begin
        if (tick) last_tick = tick_num;
        if (cmd_valid && !prev_valid) chk("valid_after_tick", int'(tick), 1);
        prev_valid = cmd_valid;
        if (cmd_valid && cmd_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_cmd", int'(cmd), int'(CMD_NONE));
            end else begin
                e = sb.pop_front();
                chk("cmd", int'(cmd), int'(e.c));
                if (e.at >= 0) chk("cmd_tick", last_tick, e.at);
            end
        end
        ph = (ph + 1) % 4;
        tick = (ph == 0);
        if (tick) tick_num++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 4'd7, 3,  CMD_LEFT,   3, 1};
        vecs[1]  = '{1'b0, 4'd0, 4,  CMD_NONE,   0, 0};
        vecs[2]  = '{1'b1, 4'd9, 40, CMD_RIGHT,  3, 7};
        vecs[3]  = '{1'b0, 4'd0, 4,  CMD_NONE,   0, 0};
        vecs[4]  = '{1'b1, 4'd5, 40, CMD_ROTATE, 3, 1};
        vecs[5]  = '{1'b0, 4'd0, 4,  CMD_NONE,   0, 0};
        vecs[6]  = '{1'b1, 4'd3, 10, CMD_NONE,   0, 0};
        vecs[7]  = '{1'b0, 4'd0, 4,  CMD_NONE,   0, 0};
        vecs[8]  = '{1'b1, 4'd8, 1,  CMD_NONE,   0, 0};
        vecs[9]  = '{1'b0, 4'd0, 1,  CMD_NONE,   0, 0};
        vecs[10] = '{1'b1, 4'd8, 3,  CMD_SOFT,   3, 1};
        vecs[11] = '{1'b0, 4'd0, 4,  CMD_NONE,   0, 0};
        vecs[12] = '{1'b1, 4'd0, 1,  CMD_NONE,   0, 0};
        vecs[13] = '{1'b0, 4'd0, 2,  CMD_NONE,   0, 0};
        vecs[14] = '{1'b1, 4'd0, 3,  CMD_HARD,   3, 1};
        vecs[15] = '{1'b0, 4'd0, 4,  CMD_NONE,   0, 0};
        vecs[16] = '{1'b1, 4'd7, 20, CMD_LEFT,   3, 2};
        vecs[17] = '{1'b1, 4'd9, 10, CMD_RIGHT,  3, 1};
        vecs[18] = '{1'b0, 4'd0, 4,  CMD_NONE,   0, 0};

        repeat (3) @(posedge clk);
        #2;
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_cmd", int'(cmd), int'(CMD_NONE));
        chk("rst_ovf", int'(ovf), 0);
        reset = 1'b1;
        cmd_ready = 1'b1;
        run_ticks(2);

        for (int i = 0; i < NV; i++) begin
            base = tick_num;
            for (int k = 0; k < vecs[i].n; k++)
                sb.push_back('{vecs[i].ecmd,
                               base + vecs[i].first + ((k == 0) ? 0 : DAS + ARR * (k - 1))});
            key_valid = vecs[i].kv;
            key_code  = vecs[i].code;
            run_ticks(vecs[i].nticks);
        end
        repeat (2) @(posedge clk);
        #2;
        chk("table_drained", sb.size(), 0);

        // full queue: third command is dropped and the head stays put
        cmd_ready = 1'b0;
        sb.push_back('{CMD_LEFT, -1});
        sb.push_back('{CMD_RIGHT, -1});
        key_valid = 1'b1; key_code = 4'd7; run_ticks(3);
        key_valid = 1'b0;                  run_ticks(3);
        key_valid = 1'b1; key_code = 4'd9; run_ticks(3);
        chk("ovf_before_drop", int'(ovf), 0);
        key_valid = 1'b0;                  run_ticks(3);
        key_valid = 1'b1; key_code = 4'd5; run_ticks(3);
        chk("ovf_after_drop", int'(ovf), 1);
        chk("head_held", int'(cmd), int'(CMD_LEFT));
        ovf_clr = 1'b1;
        @(posedge clk);
        #2;
        ovf_clr = 1'b0;
        chk("ovf_cleared", int'(ovf), 0);
        key_valid = 1'b0;
        cmd_ready = 1'b1;
        run_ticks(4);
        chk("full_drained", sb.size(), 0);
        chk("full_valid_low", int'(cmd_valid), 0);

        // reset in HOLD_ARR with a full queue, then a fresh debounce with the key still down
        cmd_ready = 1'b0;
        sb.push_back('{CMD_RIGHT, -1});
        sb.push_back('{CMD_RIGHT, -1});
        key_valid = 1'b1; key_code = 4'd9; run_ticks(24);
        chk("pre_rst_ovf", int'(ovf), 1);
        chk("pre_rst_valid", int'(cmd_valid), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", int'(cmd_valid), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        chk("mid_rst_cmd", int'(cmd), int'(CMD_NONE));
        sb.delete();
        run_ticks(1);
        reset = 1'b1;
        cmd_ready = 1'b1;
        base = tick_num;
        sb.push_back('{CMD_RIGHT, base + 3});
        run_ticks(5);
        chk("post_rst_cmd", sb.size(), 0);
        key_valid = 1'b0;
        run_ticks(4);
        chk("final_valid_low", int'(cmd_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
